// File: rtl/sort_ctrl_pkg.sv
// sort_ctrl_pkg: shared states, RAM mux selects and default widths for sort_ctrl.
package sort_ctrl_pkg;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_TIMEOUT_W = 16;
    typedef enum logic [2:0] {IDLE, ARM, SORT, VERIFY, DONE} ctrl_state_e;
    typedef enum logic [1:0] {SEL_HOST, SEL_SORT, SEL_SCAN} mem_sel_e;
endpackage

// File: rtl/sort_verify_scan.sv
// sort_verify_scan: walks addresses 0..len-1 and flags any decrease in the returned bytes.
module sort_verify_scan
    import sort_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] scan_addr,
    output logic              scan_done,
    output logic              ok
);
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] prev;
    logic              run, ok_q, dec;
    assign scan_addr = cnt[ADDR_W-1:0];
    assign scan_done = run && cnt == {1'b0, len};
    // rdata lags the address by one cycle, so byte cnt-1 arrives while cnt is shown
    assign dec = run && (|cnt[ADDR_W:1]) && rdata < prev;
    assign ok  = ok_q & ~dec;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            prev <= '0;
            run  <= 1'b0;
            ok_q <= 1'b1;
        end else if (start) begin
            cnt  <= '0;
            run  <= 1'b1;
            ok_q <= 1'b1;
        end else if (run) begin
            cnt  <= cnt + 1'b1;
            prev <= rdata;
            ok_q <= ok;
            run  <= !scan_done;
        end
    end
endmodule

// File: rtl/sort_ctrl.sv
// sort_ctrl: job sequencer and RAM arbiter between host and sorter; SORT_CTRL_VERIFY_EN adds a post-sort order scan.
module sort_ctrl
    import sort_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              job_go,
    input  logic [ADDR_W-1:0] job_len,
    output logic              busy,
    output logic              job_done,
    output logic              sort_ok,
    output logic              err,
    output logic              srt_start,
    input  logic              srt_rdy,
    input  logic              srt_done,
    input  logic [ADDR_W-1:0] srt_addr,
    input  logic [DATA_W-1:0] srt_wrdata,
    input  logic              srt_wren,
    output logic [DATA_W-1:0] srt_rddata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wrdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rddata
);
    ctrl_state_e       state, state_nx;
    mem_sel_e          sel;
    logic [TIMEOUT_W-1:0] wd;
    logic              tmo, scan_go, scan_done, scan_ok, long_job;
    logic [ADDR_W-1:0] scan_addr;
    // fires on the cycle whose edge would saturate the watchdog
    assign tmo = (state == ARM || state == SORT) && wd == {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    assign host_gnt   = state == IDLE && host_req && !job_go;
    assign busy       = state == ARM || state == SORT || state == VERIFY;
    assign job_done   = state == DONE;
    assign host_rdata = mem_rddata;
    assign srt_rddata = mem_rddata;
    assign mem_addr   = sel == SEL_SORT ? srt_addr : sel == SEL_SCAN ? scan_addr : host_addr;
    assign mem_wrdata = sel == SEL_SORT ? srt_wrdata : host_wdata;
    assign mem_wren   = sel == SEL_SORT ? srt_wren : host_gnt & host_we;
    always_comb begin
        state_nx  = state;
        sel       = SEL_HOST;
        srt_start = 1'b0;
        scan_go   = 1'b0;
        case (state)
            IDLE:   state_nx = job_go ? ARM : IDLE;
            ARM: begin
                sel       = SEL_SORT;
                srt_start = srt_rdy && !tmo;
                state_nx  = tmo ? DONE : srt_rdy ? SORT : ARM;
            end
            SORT: begin
                sel      = SEL_SORT;
                scan_go  = srt_done && !tmo && long_job;
                state_nx = tmo ? DONE : srt_done ? (long_job ? VERIFY : DONE) : SORT;
            end
            VERIFY: begin
                sel      = SEL_SCAN;
                state_nx = scan_done ? DONE : VERIFY;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wd          <= '0;
            err         <= 1'b0;
            sort_ok     <= 1'b1;
            host_rvalid <= 1'b0;
        end else begin
            state       <= state_nx;
            host_rvalid <= host_gnt & ~host_we;
            wd          <= (state == ARM || state == SORT) ? wd + 1'b1 : '0;
            if (state == IDLE && job_go) begin
                err     <= 1'b0;
                sort_ok <= 1'b1;
            end else if (tmo) begin
                err     <= 1'b1;
                sort_ok <= 1'b0;
            end else if (state == VERIFY && scan_done) begin
                sort_ok <= scan_ok;
            end
        end
    end
`ifdef SORT_CTRL_VERIFY_EN
    logic [ADDR_W-1:0] len_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) len_q <= '0;
        else if (state == IDLE && job_go) len_q <= job_len;
    end
    // lengths 0 and 1 are trivially ordered and skip the scan
    assign long_job = |len_q[ADDR_W-1:1];
    sort_verify_scan #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (scan_go),
        .len       (len_q),
        .rdata     (mem_rddata),
        .scan_addr (scan_addr),
        .scan_done (scan_done),
        .ok        (scan_ok)
    );
`else
    logic unused_cfg;
    assign unused_cfg = scan_go ^ (^job_len);
    assign long_job   = 1'b0;
    assign scan_addr  = '0;
    assign scan_done  = 1'b0;
    assign scan_ok    = 1'b1;
`endif
endmodule

// File: tb/tb_sort_ctrl.sv
// tb_sort_ctrl: directed bench for sort_ctrl with a RAM model and scripted sorter; honours SORT_CTRL_VERIFY_EN.
module tb_sort_ctrl;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TW = 4;
`ifdef SORT_CTRL_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    logic          tb_clk = 1'b0;
    logic          rst_n;
    logic          host_req, host_we, host_gnt, host_rvalid;
    logic [AW-1:0] host_addr, job_len, srt_addr, mem_addr;
    logic [DW-1:0] host_wdata, host_rdata, srt_wrdata, srt_rddata, mem_wrdata, mem_rddata;
    logic          job_go, busy, job_done, sort_ok, err;
    logic          srt_start, srt_rdy, srt_done, srt_wren, mem_wren;
    logic [DW-1:0] ram [256];
    logic [DW-1:0] exp_mem [11];
    int            n_tests = 0;
    int            n_fail = 0;

    always #5 tb_clk = ~tb_clk;

    sort_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
        .clk(tb_clk), .rst_n(rst_n),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .job_go(job_go), .job_len(job_len), .busy(busy), .job_done(job_done),
        .sort_ok(sort_ok), .err(err),
        .srt_start(srt_start), .srt_rdy(srt_rdy), .srt_done(srt_done), .srt_addr(srt_addr),
        .srt_wrdata(srt_wrdata), .srt_wren(srt_wren), .srt_rddata(srt_rddata),
        .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_wren(mem_wren), .mem_rddata(mem_rddata)
    );

    always @(posedge tb_clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wrdata;
        mem_rddata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i <= 11; i++) begin
            @(negedge tb_clk);
            host_req  = (i < 11);
            host_we   = 1'b0;
            host_addr = AW'(i);
            #1;
            if (i < 11) check({tag, "_gnt"}, host_gnt, 1);
            if (i > 0) begin
                check({tag, "_rvalid"}, host_rvalid, 1);
                check({tag, "_rdata"}, host_rdata, exp_mem[i-1]);
            end
        end
        @(negedge tb_clk);
        host_req = 1'b0;
    endtask

    task automatic start_job(input logic [AW-1:0] len);
        @(negedge tb_clk);
        job_go  = 1'b1;
        job_len = len;
        #1;
        check("go_blocks_host", host_gnt, 0);
        @(negedge tb_clk);
        job_go = 1'b0;
        #1;
        check("arm_busy", busy, 1);
        check("arm_start", srt_start, 1);
    endtask

    task automatic sorter_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge tb_clk);
        srt_wren   = 1'b1;
        srt_addr   = a;
        srt_wrdata = d;
        #1;
        check("sort_host_stall", host_gnt, 0);
        check("sort_start_once", srt_start, 0);
    endtask

    task automatic finish_job(input string tag, input int exp_lat, input logic exp_ok);
        int lat;
        @(negedge tb_clk);
        srt_wren = 1'b0;
        srt_done = 1'b1;
        #1;
        lat = 0;
        do begin
            @(negedge tb_clk);
            srt_done = 1'b0;
            lat++;
            #1;
            if (!job_done) check({tag, "_stall"}, host_gnt, 0);
        end while (!job_done && lat < 64);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_sort_ok"}, sort_ok, exp_ok);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench hung");
    end

    initial begin
        logic [DW-1:0] vals [11];
        int n, starts;
        vals = '{8'd10, 8'd6, 8'd0, 8'd4, 8'd3, 8'd5, 8'd2, 8'd7, 8'd1, 8'd9, 8'd8};
        for (int i = 0; i < 256; i++) ram[i] = '0;
        rst_n = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        job_go = 1'b0; job_len = '0; srt_rdy = 1'b0; srt_done = 1'b0;
        srt_addr = '0; srt_wrdata = '0; srt_wren = 1'b0;
        repeat (3) @(negedge tb_clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_job_done", job_done, 0);
        check("rst_err", err, 0);
        check("rst_sort_ok", sort_ok, 1);
        check("rst_srt_start", srt_start, 0);
        check("rst_rvalid", host_rvalid, 0);
        check("rst_mem_wren", mem_wren, 0);
        @(negedge tb_clk);
        rst_n = 1'b1;

        // load and read back, one access per cycle
        for (int i = 0; i < 11; i++) begin
            @(negedge tb_clk);
            host_req = 1'b1; host_we = 1'b1; host_addr = AW'(i); host_wdata = vals[i];
            #1;
            check("load_gnt", host_gnt, 1);
            check("load_wren", mem_wren, 1);
        end
        exp_mem = vals;
        readback("load");

        // normal job with host request held throughout
        srt_rdy = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_addr = '0;
        start_job(8'd11);
        for (int k = 0; k < 11; k++) sorter_write(AW'(k), DW'(k));
        finish_job("normal", VER ? 13 : 1, 1'b1);
        @(negedge tb_clk);
        #1;
        check("host_regrant", host_gnt, 1);
        for (int i = 0; i < 11; i++) exp_mem[i] = DW'(i);
        readback("sorted");

        // sorter leaves 3,2 at addresses 5,6
        start_job(8'd11);
        sorter_write(8'd5, 8'd3);
        sorter_write(8'd6, 8'd2);
        finish_job("bad", VER ? 13 : 1, VER ? 1'b0 : 1'b1);

        // single-element job is trivially sorted
        start_job(8'd1);
        finish_job("len1", 1, 1'b1);

        // watchdog: sorter starts but never finishes
        start_job(8'd11);
        starts = 1; n = 0;
        while (!job_done && n < 40) begin
            @(negedge tb_clk);
            n++;
            #1;
            starts += int'(srt_start);
        end
        check("tmo_latency", n, 15);
        check("tmo_err", err, 1);
        check("tmo_sort_ok", sort_ok, 0);
        check("tmo_start_count", starts, 1);
        @(negedge tb_clk);
        #1;
        check("hold_err", err, 1);
        check("hold_sort_ok", sort_ok, 0);

        // reset while the sorter owns the RAM
        host_req = 1'b0; host_addr = 8'h5A; srt_addr = 8'h33;
        start_job(8'd0);
        check("go_clears_err", err, 0);
        check("go_sets_ok", sort_ok, 1);
        @(negedge tb_clk);
        #1;
        check("sort_mux", mem_addr, 8'h33);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_start", srt_start, 0);
        check("mid_rst_sort_ok", sort_ok, 1);
        check("mid_rst_mux", mem_addr, 8'h5A);
        @(negedge tb_clk);
        rst_n = 1'b1;
        start_job(8'd0);
        finish_job("after_rst", 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sort_ctrl.md
# sort_ctrl

Job controller and memory arbiter for the selection-sort engine. Owns the single-port 256×8 working RAM and shares it between a host port (load/readback) and the sorter. It also sequences each job: grant the RAM to the sorter, start it, wait for done, then optionally scan the result. It sits between the host bus, the `Selection_sort` engine and the RAM.

## Interface
Parameters:
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 8: RAM data width.
- `TIMEOUT_W`, 16: watchdog counter width. Timeout fires at 2^TIMEOUT_W−1 cycles.

Ports (clock and reset):
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.

Ports (host):
- `host_req` in 1: host access request; held until granted.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in ADDR_W: host address.
- `host_wdata` in DATA_W: host write data.
- `host_gnt` out 1: access accepted this cycle.
- `host_rvalid` out 1: `host_rdata` valid; follows a granted read by one cycle.
- `host_rdata` out DATA_W: read data.

Ports (job control):
- `job_go` in 1: start-job pulse.
- `job_len` in ADDR_W: element count for the verify scan; sampled on `job_go`.
- `busy` out 1: job in progress.
- `job_done` out 1: one-cycle completion pulse.
- `sort_ok` out 1: verify result.
- `err` out 1: watchdog timeout.

Ports (sorter):
- `srt_start` out 1.
- `srt_rdy` in 1.
- `srt_done` in 1.
- `srt_addr` in ADDR_W.
- `srt_wrdata` in DATA_W.
- `srt_wren` in 1.
- `srt_rddata` out DATA_W.

Ports (RAM):
- `mem_addr` out ADDR_W.
- `mem_wrdata` out DATA_W.
- `mem_wren` out 1.
- `mem_rddata` in DATA_W: registered read, one-cycle latency.

## Operation
- **States:**
  - IDLE: host owns RAM.
  - ARM: wait for `srt_rdy`.
  - SORT: sorter owns RAM.
  - VERIFY: only with macro.
  - DONE: one cycle, then back to IDLE.
- **IDLE:**
  - `host_gnt = host_req & ~job_go`; this is combinational.
  - RAM mux selects host; `mem_wren = host_gnt & host_we`.
  - `job_go` captures `job_len`, sets `busy`, moves to ARM. `job_go` wins over a same-cycle `host_req`.
- **ARM:**
  - RAM mux selects the sorter (sorter idle, `mem_wren` = `srt_wren`).
  - Once `srt_rdy`=1, drive `srt_start`=1 for exactly one cycle, then move to SORT.
  - `srt_done` is ignored in ARM.
- **SORT:**
  - RAM mux selects the sorter.
  - `srt_done`=1 moves to VERIFY (macro on) or DONE (macro off).
- **Watchdog:**
  - Clears on entry to ARM and counts every cycle in ARM/SORT.
  - When saturated: set `err`, `srt_start` low, go to DONE. `sort_ok` = 0 for that job.
- **VERIFY:**
  - Controller drives `mem_addr` from 0 to `job_len`−1; `mem_wren`=0.
  - Compares each returned byte with the previous one; any decrease clears `sort_ok`.
  - `job_len` of 0 or 1: `sort_ok`=1, go straight to DONE.
- **DONE:** `job_done`=1, `busy`→0, return to IDLE.
- **Status hold:** `err` and `sort_ok` hold until the next `job_go`, which clears `err` and sets `sort_ok`=1.
- **Host outside IDLE:** `host_gnt`=0; the host holds its request and is stalled.
- **Read data:** `srt_rddata` and `host_rdata` both carry `mem_rddata` unconditionally. `host_rvalid` is registered `host_gnt & ~host_we`.
- **`job_go` while busy:** ignored.

## Timing
- **Reset values:** all outputs 0, except `sort_ok`=1. State = IDLE, watchdog = 0.
- **Reset mid-job:** asynchronous return to IDLE. `srt_start` drops immediately and the RAM mux returns to host.
- **`job_go` at cycle t:**
  - ARM at t+1.
  - Earliest `srt_start` at t+1, if `srt_rdy` is already 1.
- **`srt_done` at cycle t:**
  - Macro off: `job_done` at t+1.
  - Macro on: VERIFY spans `job_len`+1 cycles, then `job_done`.
- **Host read:** granted at t, `host_rvalid` and data at t+1. Host write commits at the t edge.
- **Host throughput:** back-to-back host accesses sustain one per cycle in IDLE.

## Configuration
- Macro: `SORT_CTRL_VERIFY_EN`.
- **Defined:** VERIFY state, scan address counter and comparator are compiled in, and `sort_ok` reflects the scan.
- **Undefined:** SORT goes directly to DONE and `sort_ok` is tied to 1, except that a timeout clears it. `job_len` is unused.

## Structure
- **`sort_ctrl_pkg`:**
  - `ctrl_state_e` enum (IDLE, ARM, SORT, VERIFY, DONE).
  - Default `ADDR_W`/`DATA_W`/`TIMEOUT_W` localparams.
  - RAM mux select enum (`SEL_HOST`, `SEL_SORT`, `SEL_SCAN`).
- **Sub-module `sort_verify_scan`:** address counter, previous-byte register and comparator. It is instantiated only under the macro, with `start`/`len` in and `scan_addr`/`scan_done`/`ok` out.

## Test plan
1. **Load and read back:** host writes 10,6,0,4,3,5,2,7,1,9,8 to addresses 0–10, then reads them back → each `host_rvalid` arrives one cycle after `host_gnt` with matching data.
2. **Normal job:** `job_go` with `job_len`=11 and a sorter model that produces 0..10 → one `srt_start` pulse, then `job_done`; `sort_ok`=1, `err`=0; host readback gives 0,1,…,10.
3. **Host stalled during job:** `host_req` held during SORT → `host_gnt`=0 throughout; granted in the first IDLE cycle after `job_done`.
4. **Bad sorter (macro on):** sorter leaves 3 at address 5 and 2 at address 6 → `sort_ok`=0 at `job_done`.
5. **Timeout:** sorter never asserts `srt_done`, with `TIMEOUT_W`=4 → `err`=1 and `job_done` 15 cycles after ARM entry.
6. **Reset mid-job:** `rst_n` low during SORT → `busy`=0, `srt_start`=0 and `sort_ok`=1 immediately; the next `job_go` runs normally.
